fifo_push_arbiter: RTL

//  Round-robin arbiter and occupancy controller sharing one byte-wide FIFO among NUM_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 34 +++
 rtl/fifo_push_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and widths for the FIFO push arbiter.
package fifo_arb_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StLock  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from ptr_i+1, wrapping, and returns
// the first requester as both a one-hot vector and an index.
module rr_pick #(
    parameter int unsigned NumReq = 4
) (
    input  logic [NumReq-1:0]         req_i,
    input  logic [$clog2(NumReq)-1:0] ptr_i,
    output logic                      valid_o,
    output logic [NumReq-1:0]         onehot_o,
    output logic [$clog2(NumReq)-1:0] idx_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    int k;

    always_comb begin
        valid_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        k        = 0;
        // Walk from farthest to nearest so the nearest requester is the last (winning) write.
        for (int i = int'(NumReq); i >= 1; i--) begin
            k = (int'(ptr_i) + i) % int'(NumReq);
            if (req_i[IdxW'(k)]) begin
                valid_o  = 1'b1;
                idx_o    = IdxW'(k);
                onehot_o = '0;
                onehot_o[IdxW'(k)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter with burst lock and occupancy tracking for a shared byte FIFO.
// Optional statistics counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          lock_i,
    input  logic [DATA_W*NUM_REQ-1:0]   data_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    input  logic                        pop_req_i,
    output logic                        pop_ack_o,
    output logic                        fifo_push_o,
    output logic [DATA_W-1:0]           fifo_data_o,
    output logic                        fifo_pop_o,
    output logic [$clog2(DEPTH+1)-1:0]  level_o,
    output logic                        full_o,
    output logic                        empty_o
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [CNT_W*NUM_REQ-1:0]    grant_cnt_o,
    output logic [CNT_W-1:0]            stall_cnt_o
`endif
);

    localparam int unsigned IdxW   = $clog2(NUM_REQ);
    localparam int unsigned LvlW   = $clog2(DEPTH + 1);
    localparam int unsigned BurstW = $clog2(BURST_MAX + 1);

    arb_state_e          state_q, state_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [BurstW-1:0]   burst_q, burst_d;
    logic [LvlW-1:0]     level_q, level_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                push_q, push_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic                pick_valid;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IdxW-1:0]     pick_idx;
    logic [LvlW-1:0]     level_no_push;
    logic                space;
    logic                lock_hold;
    logic [DATA_W-1:0]   data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
        assign data_arr[g] = data_i[g*DATA_W +: DATA_W];
    end

    assign pop_ack_o     = pop_req_i & (level_q != '0);
    assign level_no_push = level_q - LvlW'(pop_ack_o);
    assign space         = level_no_push < LvlW'(DEPTH);
    // While locked, ptr_q holds the locked producer.
    assign lock_hold     = (state_q == StLock) && req_i[ptr_q] && lock_i[ptr_q] &&
                           (burst_q < BurstW'(BURST_MAX));

    rr_pick #(
        .NumReq (NUM_REQ)
    ) u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        gnt_d   = '0;
        push_d  = 1'b0;
        data_d  = data_q;
        if (lock_hold) begin
            // Full while locked stalls here without advancing the burst.
            if (space) begin
                gnt_d[ptr_q] = 1'b1;
                push_d       = 1'b1;
                data_d       = data_arr[ptr_q];
                burst_d      = burst_q + BurstW'(1);
            end
        end else if (pick_valid && space) begin
            gnt_d  = pick_onehot;
            push_d = 1'b1;
            data_d = data_arr[pick_idx];
            ptr_d  = pick_idx;
            if (lock_i[pick_idx]) begin
                state_d = StLock;
                burst_d = BurstW'(1);
            end else begin
                state_d = StGrant;
                burst_d = '0;
            end
        end else begin
            state_d = StIdle;
            burst_d = '0;
        end
        level_d = level_q + LvlW'(push_d) - LvlW'(pop_ack_o);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            burst_q <= '0;
            level_q <= '0;
            gnt_q   <= '0;
            push_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            level_q <= level_d;
            gnt_q   <= gnt_d;
            push_q  <= push_d;
            data_q  <= data_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign fifo_push_o = push_q;
    assign fifo_data_o = data_q;
    assign fifo_pop_o  = pop_ack_o;
    assign level_o     = level_q;
    assign full_o      = (level_q == LvlW'(DEPTH));
    assign empty_o     = (level_q == '0);

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else if (gnt_d[g] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
        assign grant_cnt_o[g*CNT_W +: CNT_W] = cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if ((|req_i) && !space) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
